eight_add_ctrl: RTL

EIGHT_ADD_CTRL -- requirements
Module: eight_add_ctrl

---
 rtl/eight_add_ctrl_pkg.sv | 13 +
 rtl/eight_add_ctrl_if.sv | 17 +
 rtl/pb_debounce.sv | 50 +++++
 rtl/eight_add_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/eight_add_ctrl_pkg.sv
// Shared constants and state encoding for the two-operand adder entry controller.
package eight_add_ctrl_pkg;
  localparam int OPW            = 7;
  localparam int DEB_CYCLES_DEF = 50000;

  typedef enum logic [2:0] {
    S_ALO  = 3'd0,
    S_AHI  = 3'd1,
    S_BLO  = 3'd2,
    S_BHI  = 3'd3,
    S_DONE = 3'd4
  } state_t;
endpackage

// File: rtl/eight_add_ctrl_if.sv
// Button/switch inputs and operand/result outputs of eight_add_ctrl.
interface eight_add_ctrl_if
  import eight_add_ctrl_pkg::*;
  ;
  logic           pb;
  logic           clr;
  logic [3:0]     c;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic [OPW-1:0] sum;
  logic           cout;
  logic           valid;
  logic [2:0]     phase;

  modport master (output pb, clr, c, input a, b, sum, cout, valid, phase);
  modport slave  (input pb, clr, c, output a, b, sum, cout, valid, phase);
endinterface

// File: rtl/pb_debounce.sv
// Two-flop synchronizer, consecutive-cycle debouncer and registered press pulse.
module pb_debounce
  import eight_add_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [1:0]    fill_q;
  logic          level_q;
  logic          armed_q;
  logic [CW-1:0] cnt_q;
  logic          s;
  logic          flip;

  assign s    = sync_q[1];
  assign flip = (s != level_q) && (cnt_q == CW'(DEB_CYCLES - 1));

  // Pulses stay disarmed after reset until the button is seen released,
  // so a button held through reset release never produces a press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '0;
      fill_q  <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      fill_q <= {fill_q[0], 1'b1};
      if (fill_q[1] && !s) armed_q <= 1'b1;
      if (s == level_q) begin
        cnt_q <= '0;
      end else if (flip) begin
        cnt_q   <= '0;
        level_q <= s;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      press <= flip && s && armed_q;
    end
  end
endmodule

// File: rtl/eight_add_ctrl.sv
// Nibble-wise operand entry from switches with registered 7-bit add and carry.
//   state  | meaning
//   S_ALO  | waiting to load a[3:0]
//   S_AHI  | waiting to load a[6:4]
//   S_BLO  | waiting to load b[3:0]
//   S_BHI  | waiting to load b[6:4]
//   S_DONE | result registered on first cycle, valid thereafter
module eight_add_ctrl
  import eight_add_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  eight_add_ctrl_if.slave   bus
);
  state_t         state_q, state_d;
  logic [OPW-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic           cout_q, cout_d, valid_q, valid_d;
  logic           pb_press, clr_press;
  logic [OPW:0]   add_full;

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pb_deb (
    .clk   (clk),
    .rstn  (rstn),
    .raw   (bus.pb),
    .press (pb_press)
  );

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
    .clk   (clk),
    .rstn  (rstn),
    .raw   (bus.clr),
    .press (clr_press)
  );

  assign add_full = {1'b0, a_q} + {1'b0, b_q};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_ALO;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = 1'b0;
    if (clr_press) begin
      state_d = S_ALO;
      a_d     = '0;
      b_d     = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
    end else begin
      case (state_q)
        S_ALO: if (pb_press) begin
          a_d     = {a_q[6:4], bus.c};
          state_d = S_AHI;
        end
        S_AHI: if (pb_press) begin
          a_d     = {bus.c[2:0], a_q[3:0]};
          state_d = S_BLO;
        end
        S_BLO: if (pb_press) begin
          b_d     = {b_q[6:4], bus.c};
          state_d = S_BHI;
        end
        S_BHI: if (pb_press) begin
          b_d     = {bus.c[2:0], b_q[3:0]};
          state_d = S_DONE;
        end
        S_DONE: begin
          if (pb_press) begin
            state_d = S_ALO;
          end else if (!valid_q) begin
            sum_d   = add_full[OPW-1:0];
            cout_d  = add_full[OPW];
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b1;
          end
        end
        default: state_d = S_ALO;
      endcase
    end
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.valid = valid_q;
  assign bus.phase = state_q;
endmodule
